// File: rtl/i2c_master_tx_engine.sv
// -----------------------------------------------------------------------------
// i2c_master_tx_engine
//
// Bit/byte engine for an I2C master write. It serialises START, the 7-bit
// slave address plus W bit, then as many transmit-FIFO bytes as are present,
// and finally a STOP. Every bit is split into four "quarters" of CLKDIV clk
// cycles each, so SDA can change while SCL is low and stay stable while SCL
// is high.
//
// Ports:
//   clk              system clock
//   reset            asynchronous, active-low reset
//   start            one-cycle request to begin a transaction (ignored when busy)
//   slave_address    7-bit target address, sampled when start is accepted
//   fifo_rd_data     head-of-FIFO byte, valid while fifo_empty = 0
//   fifo_empty       transmit FIFO empty flag
//   fifo_rd_request  one-cycle pop strobe, coincident with the shift load
//   busy             high from start acceptance until the done cycle
//   ack_error        sticky NACK flag, cleared by the next accepted start
//   done             one-cycle pulse at the end of STOP
//   I2C_SCL          SCL level (1 = released)
//   I2C_SDA_OE       1 = pull SDA low, 0 = release
//   I2C_SDA_IN       sampled SDA pin level
// -----------------------------------------------------------------------------
module i2c_master_tx_engine #(
  parameter int CLKDIV = 125,
  parameter int CW     = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] slave_address,
  input  logic [7:0] fifo_rd_data,
  input  logic       fifo_empty,
  output logic       fifo_rd_request,
  output logic       busy,
  output logic       ack_error,
  output logic       done,
  output logic       I2C_SCL,
  output logic       I2C_SDA_OE,
  input  logic       I2C_SDA_IN
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_BIT   = 3'd2,
    ST_ACK   = 3'd3,
    ST_STOP  = 3'd4
  } state_t;

  localparam logic [CW-1:0] CNT_LAST = CW'(CLKDIV - 1);

  state_t        state_reg, state_next;
  logic [1:0]    q_reg, q_next;            // quarter index inside the phase
  logic [2:0]    bit_reg, bit_next;        // bit index inside the byte
  logic [7:0]    shift_reg, shift_next;    // MSB is the bit on the wire
  logic [CW-1:0] cnt_reg, cnt_next;        // quarter-period counter
  logic          ack_sample_reg, ack_sample_next;
  logic          ack_error_reg, ack_error_next;
  logic          done_reg, done_next;
  logic          busy_reg, busy_next;
  logic          scl_reg, scl_next;
  logic          sda_oe_reg, sda_oe_next;
  logic          tick;
  logic          rd_req;

  // Bus levels {scl, sda_oe} for a given phase/quarter. The line registers
  // are loaded from the *next* state so SCL/SDA come straight from flops and
  // never glitch on a multi-bit state change.
  function automatic logic [1:0] line_levels(input state_t st,
                                             input logic [1:0] q,
                                             input logic b);
    logic [1:0] lv;
    case (st)
      // SDA falls while SCL is high, then SCL drops in Q2 with SDA still low.
      ST_START: lv = {(q != 2'd2), 1'b1};
      // Data is driven for the whole slot; SCL is high only in Q1/Q2.
      ST_BIT:   lv = {((q == 2'd1) || (q == 2'd2)), ~b};
      // Released so the slave can answer.
      ST_ACK:   lv = {((q == 2'd1) || (q == 2'd2)), 1'b0};
      // SDA held low until SCL is high, then released in Q2 (STOP condition).
      ST_STOP:  lv = {(q != 2'd0), (q[1] == 1'b0)};
      default:  lv = 2'b10;
    endcase
    return lv;
  endfunction

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= ST_IDLE;
      q_reg          <= 2'd0;
      bit_reg        <= 3'd0;
      shift_reg      <= 8'h00;
      cnt_reg        <= '0;
      ack_sample_reg <= 1'b0;
      ack_error_reg  <= 1'b0;
      done_reg       <= 1'b0;
      busy_reg       <= 1'b0;
      scl_reg        <= 1'b1;
      sda_oe_reg     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      q_reg          <= q_next;
      bit_reg        <= bit_next;
      shift_reg      <= shift_next;
      cnt_reg        <= cnt_next;
      ack_sample_reg <= ack_sample_next;
      ack_error_reg  <= ack_error_next;
      done_reg       <= done_next;
      busy_reg       <= busy_next;
      scl_reg        <= scl_next;
      sda_oe_reg     <= sda_oe_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next      = state_reg;
    q_next          = q_reg;
    bit_next        = bit_reg;
    shift_next      = shift_reg;
    ack_sample_next = ack_sample_reg;
    ack_error_next  = ack_error_reg;
    done_next       = 1'b0;
    rd_req          = 1'b0;

    tick = (cnt_reg == CNT_LAST);

    // The counter only runs inside a transaction so every phase starts
    // from a full quarter.
    if (state_reg == ST_IDLE) begin
      cnt_next = '0;
    end else if (tick) begin
      cnt_next = '0;
    end else begin
      cnt_next = cnt_reg + CW'(1);
    end

    case (state_reg)
      ST_IDLE: begin
        // A start arriving in the done cycle is dropped on purpose so the
        // register block sees a clean done before anything new begins.
        if (start && !done_reg) begin
          shift_next     = {slave_address, 1'b0};
          ack_error_next = 1'b0;
          bit_next       = 3'd0;
          q_next         = 2'd0;
          state_next     = ST_START;
        end
      end

      ST_START: begin
        if (tick) begin
          if (q_reg == 2'd2) begin
            q_next     = 2'd0;
            state_next = ST_BIT;
          end else begin
            q_next = q_reg + 2'd1;
          end
        end
      end

      ST_BIT: begin
        if (tick) begin
          if (q_reg == 2'd3) begin
            q_next     = 2'd0;
            shift_next = {shift_reg[6:0], 1'b0};
            if (bit_reg == 3'd7) begin
              bit_next   = 3'd0;
              state_next = ST_ACK;
            end else begin
              bit_next = bit_reg + 3'd1;
            end
          end else begin
            q_next = q_reg + 2'd1;
          end
        end
      end

      ST_ACK: begin
        if (tick) begin
          // Sample in the middle of the SCL-high window.
          if (q_reg == 2'd1) begin
            ack_sample_next = I2C_SDA_IN;
          end
          if (q_reg == 2'd3) begin
            q_next = 2'd0;
            if (ack_sample_reg) begin
              ack_error_next = 1'b1;
              state_next     = ST_STOP;
            end else if (fifo_empty) begin
              state_next = ST_STOP;
            end else begin
              // Pop and load in the same cycle: the byte consumed is exactly
              // the one presented on fifo_rd_data.
              rd_req     = 1'b1;
              shift_next = fifo_rd_data;
              state_next = ST_BIT;
            end
          end else begin
            q_next = q_reg + 2'd1;
          end
        end
      end

      ST_STOP: begin
        if (tick) begin
          if (q_reg == 2'd3) begin
            q_next     = 2'd0;
            done_next  = 1'b1;
            state_next = ST_IDLE;
          end else begin
            q_next = q_reg + 2'd1;
          end
        end
      end

      default: begin
        state_next = ST_IDLE;
        q_next     = 2'd0;
      end
    endcase

    busy_next                 = (state_next != ST_IDLE);
    {scl_next, sda_oe_next}   = line_levels(state_next, q_next, shift_next[7]);
  end

  assign fifo_rd_request = rd_req;
  assign busy            = busy_reg;
  assign ack_error       = ack_error_reg;
  assign done            = done_reg;
  assign I2C_SCL         = scl_reg;
  assign I2C_SDA_OE      = sda_oe_reg;

endmodule
